ysyx_22050058_div_ctrl: RTL and testbench
=========================================

# ysyx_22050058_div_ctrl

Front-end and back-end controller for the pipelined unsigned divider core. It accepts RV64M divide/remainder ops from the EXU over a valid/ready handshake and converts signed operands to magnitudes. It resolves divide-by-zero and signed overflow without using the core, issues legal ops to the core, and sign-corrects the returned quotient/remainder into one architectural result. One op is in flight at a time.

## Interface

- WIDTH, 64, datapath width (XLEN)
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  op request valid
- req_ready_o  out  1  controller can accept (IDLE only)
- req_op_i  in  3  [0]=unsigned, [1]=remainder, [2]=word (32-bit) op
- req_src1_i  in  WIDTH  dividend
- req_src2_i  in  WIDTH  divisor
- flush_i  in  1  cancel any in-flight op
- resp_valid_o  out  1  result valid, held until taken
- resp_ready_i  in  1  consumer takes result
- resp_data_o  out  WIDTH  architectural result
- div_valid_o  out  1  one-cycle issue pulse to core
- div_dividend_o  out  WIDTH  unsigned dividend magnitude
- div_divisor_o  out  WIDTH  unsigned divisor magnitude (never zero when issued)
- div_qr_valid_i  in  1  core result valid
- div_quotient_i  in  WIDTH  core quotient
- div_remainder_i  in  WIDTH  core remainder

## Operation

- States: IDLE, ISSUE, WAIT, DRAIN, DONE. Reset → IDLE.
- Reset values: resp_valid_o=0, resp_data_o=0, div_valid_o=0, div_dividend_o=0, div_divisor_o=0. req_ready_o is 1 whenever the state is IDLE.
- IDLE: accept on req_valid_i && req_ready_o && !flush_i. Register op and operands. Next state:
  - DONE if divisor is zero or the op is a signed overflow.
  - ISSUE otherwise.
- Operand prep for word ops: take bits [31:0] of each operand, then sign-extend (signed) or zero-extend (unsigned) to WIDTH. Full-width ops use the operands unchanged.
- Magnitudes: signed ops negate negative operands (two's complement, WIDTH bits). The most-negative value maps to 2^(WIDTH-1) unsigned.
- Special cases, evaluated on the prepared operands:
  - Divisor zero: quotient = all ones, remainder = prepared dividend.
  - Signed overflow (dividend = most negative, divisor = -1): quotient = dividend, remainder = 0.
- ISSUE: div_valid_o=1 for exactly one cycle with the magnitudes, then go to WAIT.
- WAIT: on div_qr_valid_i, compute the result and go to DONE.
  - Negate the quotient if the op is signed and the operand signs differ.
  - Negate the remainder if the op is signed and the dividend is negative.
  - Select the remainder if op[1]=1, otherwise the quotient.
- Word result: bits [31:0] of the selected value, sign-extended from bit 31. This applies to divuw/remuw too.
- DONE: resp_valid_o=1 with resp_data_o stable. Go to IDLE on resp_ready_i.
- Flush handling:
  - IDLE: no accept.
  - ISSUE: no issue pulse; go to IDLE.
  - WAIT: go to DRAIN.
  - DONE: drop the response; go to IDLE.
- DRAIN: ignore flush_i. Discard the next div_qr_valid_i, then go to IDLE. The core has fixed latency, so the orphan result always arrives.
- div_qr_valid_i in IDLE, ISSUE or DONE: ignored.

## Timing

- Accept at cycle 0. For a legal op: ISSUE at cycle 1, so div_valid_o is high at cycle 1.
- With core latency L (cycles from div_valid_o to div_qr_valid_i, L=33 for the current core): div_qr_valid_i at cycle 1+L. resp_valid_o first high at cycle 2+L.
- Special case: resp_valid_o high at cycle 1; the core sees no traffic.
- Back-to-back ops: with resp_ready_i held high, req_ready_o returns high the cycle after the response handshake.
- Flush during WAIT: req_ready_o stays low until the cycle after the drained div_qr_valid_i.
- Reset mid-op: all state returns to IDLE next edge. A late div_qr_valid_i is ignored.

## Structure

- Shared package holds:
  - OP bit positions: OP_UNS=0, OP_REM=1, OP_W=2.
  - State encoding.
  - Helper function for WIDTH-bit two's-complement negate.
- Sub-module ysyx_22050058_div_sign (combinational) handles word extension, magnitudes, special-case detection and post-correction.
- The divider core is instantiated by the parent, not inside this block.

## Test plan

- div -7 / 2 (full width) → one div_valid_o pulse with 7 and 2. Core returns q=3, r=1; resp_data_o = -3 at cycle 2+L.
- rem -7 / 2 → resp_data_o = -1. remu 7 / 0 → resp_data_o = 7 at cycle 1 with no div_valid_o.
- div 0x8000_0000_0000_0000 / -1 → resp_data_o = 0x8000_0000_0000_0000 at cycle 1. divw with src1 low word 0x8000_0000 / -1 → resp_data_o = 0xFFFF_FFFF_8000_0000.
- divuw 0xFFFF_FFFF / 1 → resp_data_o = 0xFFFF_FFFF_FFFF_FFFF (bit-31 sign-extension). divu 10/0 → all ones.
- flush_i for one cycle mid-WAIT, then a new req offered → req_ready_o low until the drained qr_valid; no resp_valid_o for the flushed op. The new op completes with its correct result.
- resp_ready_i held low 5 cycles → resp_valid_o/resp_data_o stable for 5 cycles. Assert rst_i mid-WAIT → IDLE and outputs zero next cycle; the late qr_valid produces no response.

Source files
------------

// File: rtl/ysyx_22050058_div_ctrl_pkg.sv
// Shared definitions for the divider controller: op bit positions, FSM
// encoding and width-fixed arithmetic helpers.
package ysyx_22050058_div_ctrl_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned OP_BITS   = 3;
    localparam int unsigned WORD_BITS = 32;

    // Op field bit positions
    localparam int unsigned OP_UNS = 0;
    localparam int unsigned OP_REM = 1;
    localparam int unsigned OP_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } div_state_e;

    // Two's-complement negate at datapath width
    function automatic logic [XLEN-1:0] neg_xlen(input logic [XLEN-1:0] a);
        return (~a) + XLEN'(1);
    endfunction

    // Word ops keep bits [31:0] sign-extended from bit 31; full-width ops pass through
    function automatic logic [XLEN-1:0] fmt_result(input logic word, input logic [XLEN-1:0] v);
        return word ? {{(XLEN-WORD_BITS){v[WORD_BITS-1]}}, v[WORD_BITS-1:0]} : v;
    endfunction

endpackage

// File: rtl/ysyx_22050058_div_sign.sv
// Combinational sign handling around the unsigned divider core.
// Request side: word extension, operand magnitudes, divide-by-zero and
// signed-overflow detection with the architectural result for those cases.
// Response side: sign correction of the core quotient/remainder and
// quotient/remainder selection with word formatting.
//   i_req_op/i_req_src1/i_req_src2 : live request op and raw operands
//   o_*_c (request side)           : magnitudes, sign flags, special result
//   i_res_*                        : registered op and sign flags of the in-flight op
//   i_quotient/i_remainder         : unsigned core results
//   o_result_c                     : architectural result of a core op
module ysyx_22050058_div_sign
    import ysyx_22050058_div_ctrl_pkg::*;
(
    input  logic [OP_BITS-1:0] i_req_op,
    input  logic [XLEN-1:0]    i_req_src1,
    input  logic [XLEN-1:0]    i_req_src2,
    output logic [XLEN-1:0]    o_dividend_mag_c,
    output logic [XLEN-1:0]    o_divisor_mag_c,
    output logic               o_neg_q_c,
    output logic               o_neg_r_c,
    output logic               o_special_c,
    output logic [XLEN-1:0]    o_special_data_c,
    input  logic [OP_BITS-1:0] i_res_op,
    input  logic               i_res_neg_q,
    input  logic               i_res_neg_r,
    input  logic [XLEN-1:0]    i_quotient,
    input  logic [XLEN-1:0]    i_remainder,
    output logic [XLEN-1:0]    o_result_c
);

    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD = {{(XLEN-WORD_BITS+1){1'b1}}, {(WORD_BITS-1){1'b0}}};

    logic            w_signed;
    logic            w_word;
    logic [XLEN-1:0] w_src1_p;
    logic [XLEN-1:0] w_src2_p;
    logic            w_neg1;
    logic            w_neg2;
    logic            w_div_zero;
    logic            w_overflow;
    logic [XLEN-1:0] w_spec_q;
    logic [XLEN-1:0] w_spec_r;
    logic [XLEN-1:0] w_res_q;
    logic [XLEN-1:0] w_res_r;

    assign w_signed = !i_req_op[OP_UNS];
    assign w_word   = i_req_op[OP_W];

    // Prepared operands: word ops extend the low word by signedness
    always_comb begin
        w_src1_p = i_req_src1;
        w_src2_p = i_req_src2;
        if (w_word) begin
            if (w_signed) begin
                w_src1_p = {{(XLEN-WORD_BITS){i_req_src1[WORD_BITS-1]}}, i_req_src1[WORD_BITS-1:0]};
                w_src2_p = {{(XLEN-WORD_BITS){i_req_src2[WORD_BITS-1]}}, i_req_src2[WORD_BITS-1:0]};
            end else begin
                w_src1_p = {{(XLEN-WORD_BITS){1'b0}}, i_req_src1[WORD_BITS-1:0]};
                w_src2_p = {{(XLEN-WORD_BITS){1'b0}}, i_req_src2[WORD_BITS-1:0]};
            end
        end
    end

    assign w_neg1 = w_signed && w_src1_p[XLEN-1];
    assign w_neg2 = w_signed && w_src2_p[XLEN-1];

    assign o_dividend_mag_c = w_neg1 ? neg_xlen(w_src1_p) : w_src1_p;
    assign o_divisor_mag_c  = w_neg2 ? neg_xlen(w_src2_p) : w_src2_p;
    assign o_neg_q_c        = w_neg1 ^ w_neg2;
    assign o_neg_r_c        = w_neg1;

    // Most-negative is judged at the op's own width
    assign w_div_zero = (w_src2_p == '0);
    assign w_overflow = w_signed && (w_src2_p == '1)
                        && (w_src1_p == (w_word ? MIN_WORD : MIN_FULL));
    assign o_special_c = w_div_zero || w_overflow;

    // Divide-by-zero wins; overflow gives q = dividend, r = 0
    assign w_spec_q = w_div_zero ? '1 : w_src1_p;
    assign w_spec_r = w_div_zero ? w_src1_p : '0;
    assign o_special_data_c = fmt_result(w_word, i_req_op[OP_REM] ? w_spec_r : w_spec_q);

    // Post-correction of core results
    assign w_res_q    = i_res_neg_q ? neg_xlen(i_quotient) : i_quotient;
    assign w_res_r    = i_res_neg_r ? neg_xlen(i_remainder) : i_remainder;
    assign o_result_c = fmt_result(i_res_op[OP_W], i_res_op[OP_REM] ? w_res_r : w_res_q);

endmodule

// File: rtl/ysyx_22050058_div_ctrl.sv
// Divider controller: accepts RV64M div/rem ops, resolves divide-by-zero
// and signed overflow locally, issues legal ops to the unsigned core as a
// one-cycle pulse, and sign-corrects the core result. One op in flight.
//   clk_i/rst_i           : clock, synchronous active-high reset
//   req_*                 : op request handshake and operands
//   flush_i               : cancel the in-flight op
//   resp_*                : result handshake, data held until taken
//   div_valid_o/div_*_o   : issue pulse and magnitudes to the core
//   div_qr_valid_i/div_*_i: core result (fixed latency)
module ysyx_22050058_div_ctrl
    import ysyx_22050058_div_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [OP_BITS-1:0] req_op_i,
    input  logic [XLEN-1:0]    req_src1_i,
    input  logic [XLEN-1:0]    req_src2_i,
    input  logic               flush_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [XLEN-1:0]    resp_data_o,
    output logic               div_valid_o,
    output logic [XLEN-1:0]    div_dividend_o,
    output logic [XLEN-1:0]    div_divisor_o,
    input  logic               div_qr_valid_i,
    input  logic [XLEN-1:0]    div_quotient_i,
    input  logic [XLEN-1:0]    div_remainder_i
);

    localparam int unsigned WIDTH = XLEN;

    div_state_e         r_state;
    div_state_e         w_next_state;
    logic [OP_BITS-1:0] r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_resp_data;

    logic               w_accept;
    logic               w_capture;
    logic [WIDTH-1:0]   w_dividend_mag;
    logic [WIDTH-1:0]   w_divisor_mag;
    logic               w_neg_q;
    logic               w_neg_r;
    logic               w_special;
    logic [WIDTH-1:0]   w_special_data;
    logic [WIDTH-1:0]   w_result;

    ysyx_22050058_div_sign u_sign (
        .i_req_op         (req_op_i),
        .i_req_src1       (req_src1_i),
        .i_req_src2       (req_src2_i),
        .o_dividend_mag_c (w_dividend_mag),
        .o_divisor_mag_c  (w_divisor_mag),
        .o_neg_q_c        (w_neg_q),
        .o_neg_r_c        (w_neg_r),
        .o_special_c      (w_special),
        .o_special_data_c (w_special_data),
        .i_res_op         (r_op),
        .i_res_neg_q      (r_neg_q),
        .i_res_neg_r      (r_neg_r),
        .i_quotient       (div_quotient_i),
        .i_remainder      (div_remainder_i),
        .o_result_c       (w_result)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath enables
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i && !flush_i) begin
                    w_accept     = 1'b1;
                    w_next_state = w_special ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = flush_i ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                // A flush coinciding with the result consumes it, so nothing is left to drain
                if (flush_i) begin
                    w_next_state = div_qr_valid_i ? ST_IDLE : ST_DRAIN;
                end else if (div_qr_valid_i) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (div_qr_valid_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (flush_i || resp_ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Op context, core operands and response data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op        <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_resp_data <= '0;
        end else if (w_accept) begin
            r_op       <= req_op_i;
            r_neg_q    <= w_neg_q;
            r_neg_r    <= w_neg_r;
            r_dividend <= w_dividend_mag;
            r_divisor  <= w_divisor_mag;
            if (w_special) begin
                r_resp_data <= w_special_data;
            end
        end else if (w_capture) begin
            r_resp_data <= w_result;
        end
    end

    assign req_ready_o    = (r_state == ST_IDLE);
    assign resp_valid_o   = (r_state == ST_DONE);
    assign resp_data_o    = r_resp_data;
    // A flush in the issue cycle suppresses the pulse itself
    assign div_valid_o    = (r_state == ST_ISSUE) && !flush_i;
    assign div_dividend_o = r_dividend;
    assign div_divisor_o  = r_divisor;

endmodule

// File: tb/tb_ysyx_22050058_div_ctrl.sv
// Directed bench for the divider controller with a fixed-latency core model.
module tb_ysyx_22050058_div_ctrl;

    localparam int unsigned W      = 64;
    localparam int unsigned L      = 33;
    localparam int          BUDGET = 200;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_src1;
    logic [W-1:0] req_src2;
    logic         flush;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         div_valid;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         qr_valid;
    logic [W-1:0] qr_q;
    logic [W-1:0] qr_r;

    int n_tests;
    int n_fail;
    int n_pulses;
    int core_cnt;

    ysyx_22050058_div_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_src1_i     (req_src1),
        .req_src2_i     (req_src2),
        .flush_i        (flush),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_data_o    (resp_data),
        .div_valid_o    (div_valid),
        .div_dividend_o (div_dividend),
        .div_divisor_o  (div_divisor),
        .div_qr_valid_i (qr_valid),
        .div_quotient_i (qr_q),
        .div_remainder_i(qr_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-latency unsigned core; deliberately not reset so late results appear
    always @(posedge clk) begin
        if (div_valid) begin
            n_pulses <= n_pulses + 1;
            core_cnt <= L - 1;
            qr_q     <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
            qr_r     <= (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;
            qr_valid <= 1'b0;
        end else if (core_cnt == 1) begin
            qr_valid <= 1'b1;
            core_cnt <= 0;
        end else begin
            qr_valid <= 1'b0;
            if (core_cnt > 1) core_cnt <= core_cnt - 1;
        end
    end

    // Offer one op in cycle 0; returns at the negedge of cycle 1
    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Cycle (relative to accept) at which resp_valid is first seen, bounded
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || div_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b resp_valid=%b div_valid=%b, want 1 0 0", req_ready, resp_valid, div_valid);
        end
        n_tests++;
        if (resp_data !== '0 || div_dividend !== '0 || div_divisor !== '0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h dvd=%h dvs=%h, want all zero", resp_data, div_dividend, div_divisor);
        end
    endtask

    task automatic test_div_signed();
        int lat;
        int p0;
        p0 = n_pulses;
        start_op(3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        n_tests++;
        if (div_valid !== 1'b1 || div_dividend !== 64'd7 || div_divisor !== 64'd2) begin
            n_fail++;
            $display("FAIL div_issue: valid=%b dvd=%h dvs=%h, want 1 7 2", div_valid, div_dividend, div_divisor);
        end
        wait_resp(lat);
        n_tests++;
        if (lat !== 2 + L) begin
            n_fail++;
            $display("FAIL div_latency: got %0d, want %0d", lat, 2 + L);
        end
        n_tests++;
        if (resp_data !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_neg7_2: got %h, want fffffffffffffffd", resp_data);
        end
        take_resp();
        n_tests++;
        if (n_pulses - p0 !== 1) begin
            n_fail++;
            $display("FAIL div_pulses: got %0d, want 1", n_pulses - p0);
        end
    endtask

    task automatic test_rem_signed();
        int lat;
        start_op(3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_resp(lat);
        n_tests++;
        if (lat !== 2 + L || resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL rem_neg7_2: lat=%0d data=%h, want %0d ffffffffffffffff", lat, resp_data, 2 + L);
        end
        take_resp();
    endtask

    task automatic test_special();
        int lat;
        int p0;
        p0 = n_pulses;
        start_op(3'b011, 64'd7, 64'd0);
        wait_resp(lat);
        n_tests++;
        if (lat !== 1 || resp_data !== 64'd7) begin
            n_fail++;
            $display("FAIL remu_7_0: lat=%0d data=%h, want 1 7", lat, resp_data);
        end
        take_resp();
        start_op(3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_resp(lat);
        n_tests++;
        if (lat !== 1 || resp_data !== 64'h8000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL div_overflow: lat=%0d data=%h, want 1 8000000000000000", lat, resp_data);
        end
        take_resp();
        start_op(3'b001, 64'd10, 64'd0);
        wait_resp(lat);
        n_tests++;
        if (lat !== 1 || resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL divu_10_0: lat=%0d data=%h, want 1 ffffffffffffffff", lat, resp_data);
        end
        take_resp();
        n_tests++;
        if (n_pulses - p0 !== 0) begin
            n_fail++;
            $display("FAIL special_pulses: got %0d, want 0", n_pulses - p0);
        end
        start_op(3'b100, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_resp(lat);
        n_tests++;
        if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_8000_0000) begin
            n_fail++;
            $display("FAIL divw_overflow: valid=%b data=%h, want 1 ffffffff80000000", resp_valid, resp_data);
        end
        take_resp();
    endtask

    task automatic test_word();
        int lat;
        start_op(3'b101, 64'h0000_0000_FFFF_FFFF, 64'd1);
        wait_resp(lat);
        n_tests++;
        if (lat !== 2 + L || resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL divuw_sext: lat=%0d data=%h, want %0d ffffffffffffffff", lat, resp_data, 2 + L);
        end
        take_resp();
        start_op(3'b100, 64'hDEAD_0000_0000_0064, 64'h0000_0001_FFFF_FFFD);
        wait_resp(lat);
        n_tests++;
        if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_FFFF_FFDF) begin
            n_fail++;
            $display("FAIL divw_100_m3: valid=%b data=%h, want 1 ffffffffffffffdf", resp_valid, resp_data);
        end
        take_resp();
        start_op(3'b110, 64'h0000_0000_FFFF_FFF9, 64'd2);
        wait_resp(lat);
        n_tests++;
        if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL remw_neg7_2: valid=%b data=%h, want 1 ffffffffffffffff", resp_valid, resp_data);
        end
        take_resp();
    endtask

    task automatic test_flush_wait();
        int cyc;
        int lat;
        int bad_resp;
        bad_resp = 0;
        start_op(3'b001, 64'd20, 64'd3);
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        // Cycle 5: flush while WAIT, and offer the next op from now on
        flush     = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'b001;
        req_src1  = 64'd100;
        req_src2  = 64'd7;
        @(negedge clk);
        cyc++;
        flush = 1'b0;
        while (!req_ready && cyc < BUDGET) begin
            if (resp_valid) bad_resp++;
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (cyc !== 2 + L) begin
            n_fail++;
            $display("FAIL flush_ready_cycle: got %0d, want %0d", cyc, 2 + L);
        end
        n_tests++;
        if (bad_resp !== 0) begin
            n_fail++;
            $display("FAIL flush_no_resp: got %0d resp cycles, want 0", bad_resp);
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(lat);
        n_tests++;
        if (lat !== 2 + L || resp_data !== 64'd14) begin
            n_fail++;
            $display("FAIL flush_next_op: lat=%0d data=%h, want %0d e", lat, resp_data, 2 + L);
        end
        take_resp();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [W-1:0] held;
        bad = 0;
        start_op(3'b001, 64'd100, 64'd7);
        wait_resp(lat);
        held = resp_data;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== held) bad++;
        end
        n_tests++;
        if (bad !== 0 || held !== 64'd14) begin
            n_fail++;
            $display("FAIL backpressure: unstable=%0d data=%h, want 0 e", bad, held);
        end
        take_resp();
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: ready=%b valid=%b, want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b1;
        start_op(3'b011, 64'd7, 64'd0);
        n_tests++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd7) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b data=%h, want 1 7", resp_valid, resp_data);
        end
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready: ready=%b valid=%b, want 1 0", req_ready, resp_valid);
        end
        req_valid = 1'b1;
        req_op    = 3'b001;
        req_src1  = 64'd9;
        req_src2  = 64'd0;
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b data=%h, want 1 ffffffffffffffff", resp_valid, resp_data);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready2: ready=%b, want 1", req_ready);
        end
    endtask

    task automatic test_reset_mid_wait();
        int bad;
        bad = 0;
        start_op(3'b001, 64'd50, 64'd5);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== '0
            || div_dividend !== '0 || div_divisor !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: ready=%b valid=%b data=%h dvd=%h dvs=%h, want 1 0 0 0 0",
                     req_ready, resp_valid, resp_data, div_dividend, div_divisor);
        end
        repeat (40) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_late_qr: got %0d bad cycles, want 0", bad);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        n_pulses   = 0;
        core_cnt   = 0;
        qr_valid   = 1'b0;
        qr_q       = '0;
        qr_r       = '0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_src1   = '0;
        req_src2   = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_div_signed();
        test_rem_signed();
        test_special();
        test_word();
        test_flush_wait();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
